host_reg_bank: RTL and testbench
================================

HOST_REG_BANK -- requirements
Module: host_reg_bank

Interface
REQ-001 SHALL have parameter: REG_COUNT, 35, number of mapped 16-bit registers at word addresses 0..REG_COUNT-1.
REQ-002 SHALL have ports:
- clk_reg, input, 1, sole clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-low.
- csb, input, 1, chip select, active-low.
- wrb, input, 1, 0 = write, 1 = read; qualified by csb=0.
- ca, input, 8, byte address; word address = ca[7:1]; ca[0] ignored.
- cd_in, input, 16, write data.
- cd_out, output, 16, read data.
- cfg, output, mac_cfg_t, all writable register fields, registered.
- tx_prom_wr_pulse, output, 1, one-cycle TX address-PROM write strobe.
- rx_prom_wr_pulse, output, 1, one-cycle RX address-PROM write strobe.
- cpu_rd_grant_i, input, 1, statistics-read grant from MAC core.
- cpu_rd_dout_i, input, 32, statistics-read data, valid while grant=1.

Function
REQ-003 Write: at rising edge with reset=1, csb=0, wrb=0 and word address mapped and writable, SHALL store the low W bits of cd_in into that field (W = field width from package); back-to-back writes on consecutive cycles SHALL all take effect.
REQ-004 Read: cd_out SHALL be combinational, equal to zero-extended field at ca[7:1] while csb=0 and wrb=1, else 16'h0000; read data SHALL be stable before the next rising edge after the access is driven.
REQ-005 Unmapped addresses (>= REG_COUNT): writes SHALL be ignored; reads SHALL return 16'h0000.
REQ-006 Read-only addresses 30 (CPU_rd_grant), 31 (CPU_rd_dout_l), 32 (CPU_rd_dout_h): writes SHALL be ignored.
REQ-007 Field widths: Tx_Hwmark/Tx_Lwmark/Rx_Hwmark/Rx_Lwmark 5, IFGset/RX_IFG_SET 6, MaxRetry 4, RX_MAX_LENGTH 16, RX_MIN_LENGTH 7, pause_quanta_set 16, broadcast_bucket_depth 16, broadcast_bucket_interval 16, CPU_rd_addr 6, PROM data 8, PROM add 3, Speed 3; all other fields 1.
REQ-008 PROM strobes: tx_prom_wr_pulse SHALL be high exactly one cycle, the cycle after stored MAC_tx_add_prom_wr transitions 0->1; rewriting 1 while already 1 SHALL NOT pulse; same rule for rx_prom_wr_pulse and MAC_rx_add_prom_wr.
REQ-009 CPU read handshake, states IDLE, WAIT, DONE:
- IDLE->WAIT on a write of 1 to CPU_rd_apply.
- In WAIT, cfg.cpu_rd_apply=1; when cpu_rd_grant_i=1, SHALL latch cpu_rd_dout_i[15:0] into dout_l and [31:16] into dout_h, clear cpu_rd_apply, and go to DONE.
- In DONE, CPU_rd_grant reads 1; DONE->IDLE on a write of 0 to CPU_rd_apply.
- DONE->WAIT on a write of 1 to CPU_rd_apply.
REQ-010 Simultaneous host write to CPU_rd_apply and grant in WAIT: data SHALL be latched, and the host-written apply value SHALL win (1 -> remain WAIT, 0 -> IDLE).
REQ-011 Grant while IDLE or DONE SHALL be ignored; dout_l/dout_h SHALL hold their last latched value.

Reset
REQ-012 While reset=0 at a rising edge, all fields SHALL load defaults: Tx_Hwmark 0x1E, Tx_Lwmark 0x19, IFGset 0x0C, FullDuplex 1, MaxRetry 0x2, Rx_Hwmark 0x1A, Rx_Lwmark 0x10, RX_IFG_SET 0x0C, RX_MAX_LENGTH 0x2710, RX_MIN_LENGTH 0x40, Speed 0x4; all other fields, dout_l/h, both pulses 0; handshake state IDLE.
REQ-013 Host accesses coinciding with reset=0 SHALL be ignored; reset asserted mid-handshake SHALL abort to IDLE and discard any grant in that cycle.

Structure
REQ-014 Package mac_reg_pkg SHALL hold: address constants 0..34, mac_cfg_t packed struct, field width constants, reset-default constants, and the handshake state enum.
REQ-015 One sub-module, reg_edge_pulse (0->1 detect, registered), SHALL be instantiated twice for the PROM strobes; decode and handshake SHALL stay in host_reg_bank.

Verification
REQ-016 Release reset, read addresses 0..34 -> addr 0 = 0x001E, addr 26 = 0x2710, addr 27 = 0x0040, addr 34 = 0x0004, unlisted fields 0x0000.
REQ-017 Write addr 3 = 0xFFFF, addr 0 = 0xFFFF, addr 40 = 0x1234, then read each -> 0xFFFF, 0x001F, 0x0000; cfg.pause_quanta_set = 0xFFFF one cycle after the write edge.
REQ-018 Write addr 10 = 1 twice, then 0, then 1 -> tx_prom_wr_pulse high exactly two single cycles.
REQ-019 Write addr 29 = 1, hold grant low 5 cycles, then grant=1 with dout 0xDEADBEEF -> addr 31 reads 0xBEEF, addr 32 reads 0xDEAD, addr 30 reads 1, addr 29 reads 0.
REQ-020 In WAIT, apply grant in the same cycle as a write of 0 to addr 29 -> data latched, state IDLE; then assert reset during WAIT -> apply 0, dout regs 0.

Source files
------------

// File: rtl/mac_reg_pkg.sv
// Register map, field widths, reset defaults and CPU-read handshake types
// shared by the host register bank and its consumers.
package mac_reg_pkg;

  localparam logic [6:0] A_TX_HWMARK               = 7'd0;
  localparam logic [6:0] A_TX_LWMARK               = 7'd1;
  localparam logic [6:0] A_PAUSE_FRAME_SEND_EN     = 7'd2;
  localparam logic [6:0] A_PAUSE_QUANTA_SET        = 7'd3;
  localparam logic [6:0] A_IFGSET                  = 7'd4;
  localparam logic [6:0] A_FULL_DUPLEX             = 7'd5;
  localparam logic [6:0] A_MAX_RETRY               = 7'd6;
  localparam logic [6:0] A_MAC_TX_ADD_EN           = 7'd7;
  localparam logic [6:0] A_MAC_TX_ADD_PROM_DATA    = 7'd8;
  localparam logic [6:0] A_MAC_TX_ADD_PROM_ADD     = 7'd9;
  localparam logic [6:0] A_MAC_TX_ADD_PROM_WR      = 7'd10;
  localparam logic [6:0] A_TX_PAUSE_EN             = 7'd11;
  localparam logic [6:0] A_XOFF_CPU                = 7'd12;
  localparam logic [6:0] A_XON_CPU                 = 7'd13;
  localparam logic [6:0] A_MAC_RX_ADD_CHK_EN       = 7'd14;
  localparam logic [6:0] A_MAC_RX_ADD_PROM_DATA    = 7'd15;
  localparam logic [6:0] A_MAC_RX_ADD_PROM_ADD     = 7'd16;
  localparam logic [6:0] A_MAC_RX_ADD_PROM_WR      = 7'd17;
  localparam logic [6:0] A_BROADCAST_FILTER_EN     = 7'd18;
  localparam logic [6:0] A_BROADCAST_BUCKET_DEPTH  = 7'd19;
  localparam logic [6:0] A_BROADCAST_BUCKET_INTV   = 7'd20;
  localparam logic [6:0] A_RX_APPEND_CRC           = 7'd21;
  localparam logic [6:0] A_RX_HWMARK               = 7'd22;
  localparam logic [6:0] A_RX_LWMARK               = 7'd23;
  localparam logic [6:0] A_CRC_CHK_EN              = 7'd24;
  localparam logic [6:0] A_RX_IFG_SET              = 7'd25;
  localparam logic [6:0] A_RX_MAX_LENGTH           = 7'd26;
  localparam logic [6:0] A_RX_MIN_LENGTH           = 7'd27;
  localparam logic [6:0] A_CPU_RD_ADDR             = 7'd28;
  localparam logic [6:0] A_CPU_RD_APPLY            = 7'd29;
  localparam logic [6:0] A_CPU_RD_GRANT            = 7'd30;
  localparam logic [6:0] A_CPU_RD_DOUT_L           = 7'd31;
  localparam logic [6:0] A_CPU_RD_DOUT_H           = 7'd32;
  localparam logic [6:0] A_LINE_LOOP_EN            = 7'd33;
  localparam logic [6:0] A_SPEED                   = 7'd34;

  localparam int W_WMARK     = 5;
  localparam int W_IFG       = 6;
  localparam int W_MAX_RETRY = 4;
  localparam int W_LENGTH    = 16;
  localparam int W_MIN_LEN   = 7;
  localparam int W_QUANTA    = 16;
  localparam int W_BUCKET    = 16;
  localparam int W_RD_ADDR   = 6;
  localparam int W_PROM_DATA = 8;
  localparam int W_PROM_ADD  = 3;
  localparam int W_SPEED     = 3;

  localparam logic [W_WMARK-1:0]     D_TX_HWMARK     = 5'h1E;
  localparam logic [W_WMARK-1:0]     D_TX_LWMARK     = 5'h19;
  localparam logic [W_IFG-1:0]       D_IFGSET        = 6'h0C;
  localparam logic                   D_FULL_DUPLEX   = 1'b1;
  localparam logic [W_MAX_RETRY-1:0] D_MAX_RETRY     = 4'h2;
  localparam logic [W_WMARK-1:0]     D_RX_HWMARK     = 5'h1A;
  localparam logic [W_WMARK-1:0]     D_RX_LWMARK     = 5'h10;
  localparam logic [W_IFG-1:0]       D_RX_IFG_SET    = 6'h0C;
  localparam logic [W_LENGTH-1:0]    D_RX_MAX_LENGTH = 16'h2710;
  localparam logic [W_MIN_LEN-1:0]   D_RX_MIN_LENGTH = 7'h40;
  localparam logic [W_SPEED-1:0]     D_SPEED         = 3'h4;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [W_WMARK-1:0]     tx_hwmark;
    logic [W_WMARK-1:0]     tx_lwmark;
    logic                   pause_frame_send_en;
    logic [W_QUANTA-1:0]    pause_quanta_set;
    logic [W_IFG-1:0]       ifgset;
    logic                   full_duplex;
    logic [W_MAX_RETRY-1:0] max_retry;
    logic                   mac_tx_add_en;
    logic [W_PROM_DATA-1:0] mac_tx_add_prom_data;
    logic [W_PROM_ADD-1:0]  mac_tx_add_prom_add;
    logic                   mac_tx_add_prom_wr;
    logic                   tx_pause_en;
    logic                   xoff_cpu;
    logic                   xon_cpu;
    logic                   mac_rx_add_chk_en;
    logic [W_PROM_DATA-1:0] mac_rx_add_prom_data;
    logic [W_PROM_ADD-1:0]  mac_rx_add_prom_add;
    logic                   mac_rx_add_prom_wr;
    logic                   broadcast_filter_en;
    logic [W_BUCKET-1:0]    broadcast_bucket_depth;
    logic [W_BUCKET-1:0]    broadcast_bucket_interval;
    logic                   rx_append_crc;
    logic [W_WMARK-1:0]     rx_hwmark;
    logic [W_WMARK-1:0]     rx_lwmark;
    logic                   crc_chk_en;
    logic [W_IFG-1:0]       rx_ifg_set;
    logic [W_LENGTH-1:0]    rx_max_length;
    logic [W_MIN_LEN-1:0]   rx_min_length;
    logic [W_RD_ADDR-1:0]   cpu_rd_addr;
    logic                   cpu_rd_apply;
    logic                   line_loop_en;
    logic [W_SPEED-1:0]     speed;
  } mac_cfg_t;

  function automatic mac_cfg_t cfg_reset_value();
    mac_cfg_t c;
    c               = '0;
    c.tx_hwmark     = D_TX_HWMARK;
    c.tx_lwmark     = D_TX_LWMARK;
    c.ifgset        = D_IFGSET;
    c.full_duplex   = D_FULL_DUPLEX;
    c.max_retry     = D_MAX_RETRY;
    c.rx_hwmark     = D_RX_HWMARK;
    c.rx_lwmark     = D_RX_LWMARK;
    c.rx_ifg_set    = D_RX_IFG_SET;
    c.rx_max_length = D_RX_MAX_LENGTH;
    c.rx_min_length = D_RX_MIN_LENGTH;
    c.speed         = D_SPEED;
    return c;
  endfunction

endpackage

// File: rtl/reg_edge_pulse.sv
// Registered rising-edge detector: pulse is high for one cycle, one cycle after level rises.
// Latency: 1 cycle from level change; Backpressure: none.
module reg_edge_pulse (
  input  logic clk_reg,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk_reg) begin
    if (!reset) begin
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/host_reg_bank.sv
// Host-mapped MAC configuration registers with statistics-read handshake and PROM write strobes.
// Latency: writes visible one cycle after the edge, reads combinational; Backpressure: none.
module host_reg_bank
  import mac_reg_pkg::*;
#(
  parameter int REG_COUNT = 35
) (
  input  logic        clk_reg,
  input  logic        reset,
  input  logic        csb,
  input  logic        wrb,
  input  logic [7:0]  ca,
  input  logic [15:0] cd_in,
  output logic [15:0] cd_out,
  output mac_cfg_t    cfg,
  output logic        tx_prom_wr_pulse,
  output logic        rx_prom_wr_pulse,
  input  logic        cpu_rd_grant_i,
  input  logic [31:0] cpu_rd_dout_i
);

  localparam logic [7:0] REG_LIMIT = 8'(REG_COUNT);

  mac_cfg_t    cfg_q;
  rd_state_e   rd_state_q;
  rd_state_e   rd_state_d;
  logic [15:0] dout_l_q;
  logic [15:0] dout_h_q;
  logic [15:0] rd_word;
  logic [6:0]  waddr;
  logic        mapped;
  logic        host_wr;
  logic        host_rd;
  logic        apply_wr;
  logic        rd_latch;
  logic        rd_grant;
  logic        unused_ca0;

  // Byte address from the host; bit 0 only selects a byte lane we never split.
  assign waddr      = ca[7:1];
  assign unused_ca0 = ca[0];
  assign mapped     = ({1'b0, waddr} < REG_LIMIT);
  assign host_wr    = ~csb & ~wrb & mapped;
  assign host_rd    = ~csb & wrb & mapped;
  assign apply_wr   = host_wr && (waddr == A_CPU_RD_APPLY);

  always_ff @(posedge clk_reg) begin
    if (!reset) begin
      cfg_q <= cfg_reset_value();
    end else begin
      // Grant clears apply; a host write in the same cycle is applied after and wins.
      if (rd_latch) begin
        cfg_q.cpu_rd_apply <= 1'b0;
      end
      if (host_wr) begin
        case (waddr)
          A_TX_HWMARK:              cfg_q.tx_hwmark                 <= cd_in[W_WMARK-1:0];
          A_TX_LWMARK:              cfg_q.tx_lwmark                 <= cd_in[W_WMARK-1:0];
          A_PAUSE_FRAME_SEND_EN:    cfg_q.pause_frame_send_en       <= cd_in[0];
          A_PAUSE_QUANTA_SET:       cfg_q.pause_quanta_set          <= cd_in[W_QUANTA-1:0];
          A_IFGSET:                 cfg_q.ifgset                    <= cd_in[W_IFG-1:0];
          A_FULL_DUPLEX:            cfg_q.full_duplex               <= cd_in[0];
          A_MAX_RETRY:              cfg_q.max_retry                 <= cd_in[W_MAX_RETRY-1:0];
          A_MAC_TX_ADD_EN:          cfg_q.mac_tx_add_en             <= cd_in[0];
          A_MAC_TX_ADD_PROM_DATA:   cfg_q.mac_tx_add_prom_data      <= cd_in[W_PROM_DATA-1:0];
          A_MAC_TX_ADD_PROM_ADD:    cfg_q.mac_tx_add_prom_add       <= cd_in[W_PROM_ADD-1:0];
          A_MAC_TX_ADD_PROM_WR:     cfg_q.mac_tx_add_prom_wr        <= cd_in[0];
          A_TX_PAUSE_EN:            cfg_q.tx_pause_en               <= cd_in[0];
          A_XOFF_CPU:               cfg_q.xoff_cpu                  <= cd_in[0];
          A_XON_CPU:                cfg_q.xon_cpu                   <= cd_in[0];
          A_MAC_RX_ADD_CHK_EN:      cfg_q.mac_rx_add_chk_en         <= cd_in[0];
          A_MAC_RX_ADD_PROM_DATA:   cfg_q.mac_rx_add_prom_data      <= cd_in[W_PROM_DATA-1:0];
          A_MAC_RX_ADD_PROM_ADD:    cfg_q.mac_rx_add_prom_add       <= cd_in[W_PROM_ADD-1:0];
          A_MAC_RX_ADD_PROM_WR:     cfg_q.mac_rx_add_prom_wr        <= cd_in[0];
          A_BROADCAST_FILTER_EN:    cfg_q.broadcast_filter_en       <= cd_in[0];
          A_BROADCAST_BUCKET_DEPTH: cfg_q.broadcast_bucket_depth    <= cd_in[W_BUCKET-1:0];
          A_BROADCAST_BUCKET_INTV:  cfg_q.broadcast_bucket_interval <= cd_in[W_BUCKET-1:0];
          A_RX_APPEND_CRC:          cfg_q.rx_append_crc             <= cd_in[0];
          A_RX_HWMARK:              cfg_q.rx_hwmark                 <= cd_in[W_WMARK-1:0];
          A_RX_LWMARK:              cfg_q.rx_lwmark                 <= cd_in[W_WMARK-1:0];
          A_CRC_CHK_EN:             cfg_q.crc_chk_en                <= cd_in[0];
          A_RX_IFG_SET:             cfg_q.rx_ifg_set                <= cd_in[W_IFG-1:0];
          A_RX_MAX_LENGTH:          cfg_q.rx_max_length             <= cd_in[W_LENGTH-1:0];
          A_RX_MIN_LENGTH:          cfg_q.rx_min_length             <= cd_in[W_MIN_LEN-1:0];
          A_CPU_RD_ADDR:            cfg_q.cpu_rd_addr               <= cd_in[W_RD_ADDR-1:0];
          A_CPU_RD_APPLY:           cfg_q.cpu_rd_apply              <= cd_in[0];
          A_LINE_LOOP_EN:           cfg_q.line_loop_en              <= cd_in[0];
          A_SPEED:                  cfg_q.speed                     <= cd_in[W_SPEED-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_reg) begin
    if (!reset) begin
      rd_state_q <= RD_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (apply_wr && cd_in[0]) rd_state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (apply_wr)            rd_state_d = cd_in[0] ? RD_WAIT : RD_IDLE;
        else if (cpu_rd_grant_i) rd_state_d = RD_DONE;
      end
      RD_DONE: begin
        if (apply_wr) rd_state_d = cd_in[0] ? RD_WAIT : RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_latch = (rd_state_q == RD_WAIT) && cpu_rd_grant_i;
    rd_grant = (rd_state_q == RD_DONE);
  end

  always_ff @(posedge clk_reg) begin
    if (!reset) begin
      dout_l_q <= 16'h0000;
      dout_h_q <= 16'h0000;
    end else if (rd_latch) begin
      dout_l_q <= cpu_rd_dout_i[15:0];
      dout_h_q <= cpu_rd_dout_i[31:16];
    end
  end

  always_comb begin
    rd_word = 16'h0000;
    case (waddr)
      A_TX_HWMARK:              rd_word = 16'(cfg_q.tx_hwmark);
      A_TX_LWMARK:              rd_word = 16'(cfg_q.tx_lwmark);
      A_PAUSE_FRAME_SEND_EN:    rd_word = 16'(cfg_q.pause_frame_send_en);
      A_PAUSE_QUANTA_SET:       rd_word = cfg_q.pause_quanta_set;
      A_IFGSET:                 rd_word = 16'(cfg_q.ifgset);
      A_FULL_DUPLEX:            rd_word = 16'(cfg_q.full_duplex);
      A_MAX_RETRY:              rd_word = 16'(cfg_q.max_retry);
      A_MAC_TX_ADD_EN:          rd_word = 16'(cfg_q.mac_tx_add_en);
      A_MAC_TX_ADD_PROM_DATA:   rd_word = 16'(cfg_q.mac_tx_add_prom_data);
      A_MAC_TX_ADD_PROM_ADD:    rd_word = 16'(cfg_q.mac_tx_add_prom_add);
      A_MAC_TX_ADD_PROM_WR:     rd_word = 16'(cfg_q.mac_tx_add_prom_wr);
      A_TX_PAUSE_EN:            rd_word = 16'(cfg_q.tx_pause_en);
      A_XOFF_CPU:               rd_word = 16'(cfg_q.xoff_cpu);
      A_XON_CPU:                rd_word = 16'(cfg_q.xon_cpu);
      A_MAC_RX_ADD_CHK_EN:      rd_word = 16'(cfg_q.mac_rx_add_chk_en);
      A_MAC_RX_ADD_PROM_DATA:   rd_word = 16'(cfg_q.mac_rx_add_prom_data);
      A_MAC_RX_ADD_PROM_ADD:    rd_word = 16'(cfg_q.mac_rx_add_prom_add);
      A_MAC_RX_ADD_PROM_WR:     rd_word = 16'(cfg_q.mac_rx_add_prom_wr);
      A_BROADCAST_FILTER_EN:    rd_word = 16'(cfg_q.broadcast_filter_en);
      A_BROADCAST_BUCKET_DEPTH: rd_word = cfg_q.broadcast_bucket_depth;
      A_BROADCAST_BUCKET_INTV:  rd_word = cfg_q.broadcast_bucket_interval;
      A_RX_APPEND_CRC:          rd_word = 16'(cfg_q.rx_append_crc);
      A_RX_HWMARK:              rd_word = 16'(cfg_q.rx_hwmark);
      A_RX_LWMARK:              rd_word = 16'(cfg_q.rx_lwmark);
      A_CRC_CHK_EN:             rd_word = 16'(cfg_q.crc_chk_en);
      A_RX_IFG_SET:             rd_word = 16'(cfg_q.rx_ifg_set);
      A_RX_MAX_LENGTH:          rd_word = cfg_q.rx_max_length;
      A_RX_MIN_LENGTH:          rd_word = 16'(cfg_q.rx_min_length);
      A_CPU_RD_ADDR:            rd_word = 16'(cfg_q.cpu_rd_addr);
      A_CPU_RD_APPLY:           rd_word = 16'(cfg_q.cpu_rd_apply);
      A_CPU_RD_GRANT:           rd_word = 16'(rd_grant);
      A_CPU_RD_DOUT_L:          rd_word = dout_l_q;
      A_CPU_RD_DOUT_H:          rd_word = dout_h_q;
      A_LINE_LOOP_EN:           rd_word = 16'(cfg_q.line_loop_en);
      A_SPEED:                  rd_word = 16'(cfg_q.speed);
      default:                  rd_word = 16'h0000;
    endcase
  end

  assign cd_out = host_rd ? rd_word : 16'h0000;
  assign cfg    = cfg_q;

  reg_edge_pulse u_tx_prom_pulse (
    .clk_reg (clk_reg),
    .reset   (reset),
    .level   (cfg_q.mac_tx_add_prom_wr),
    .pulse   (tx_prom_wr_pulse)
  );

  reg_edge_pulse u_rx_prom_pulse (
    .clk_reg (clk_reg),
    .reset   (reset),
    .level   (cfg_q.mac_rx_add_prom_wr),
    .pulse   (rx_prom_wr_pulse)
  );

endmodule

// File: tb/tb_host_reg_bank.sv
// Bench for host_reg_bank: address-array reference model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_host_reg_bank;
  import mac_reg_pkg::*;

  localparam int N = 35;

  logic        clk_reg = 1'b0;
  logic        reset = 1'b0;
  logic        csb = 1'b1;
  logic        wrb = 1'b1;
  logic [7:0]  ca = 8'h00;
  logic [15:0] cd_in = 16'h0000;
  logic [15:0] cd_out;
  mac_cfg_t    cfg;
  logic        tx_prom_wr_pulse;
  logic        rx_prom_wr_pulse;
  logic        cpu_rd_grant_i = 1'b0;
  logic [31:0] cpu_rd_dout_i = 32'h0;

  int errors = 0;
  int checks = 0;
  int tx_pulse_cnt = 0;

  host_reg_bank #(.REG_COUNT(N)) dut (
    .clk_reg          (clk_reg),
    .reset            (reset),
    .csb              (csb),
    .wrb              (wrb),
    .ca               (ca),
    .cd_in            (cd_in),
    .cd_out           (cd_out),
    .cfg              (cfg),
    .tx_prom_wr_pulse (tx_prom_wr_pulse),
    .rx_prom_wr_pulse (rx_prom_wr_pulse),
    .cpu_rd_grant_i   (cpu_rd_grant_i),
    .cpu_rd_dout_i    (cpu_rd_dout_i)
  );

  always #5 clk_reg = ~clk_reg;

  // Field width per word address; 0 marks read-only status words.
  function automatic int fwidth(input int a);
    case (a)
      0, 1, 22, 23:      return 5;
      3, 19, 20, 26:     return 16;
      4, 25, 28:         return 6;
      6:                 return 4;
      8, 15:             return 8;
      9, 16, 34:         return 3;
      27:                return 7;
      30, 31, 32:        return 0;
      default:           return 1;
    endcase
  endfunction

  function automatic logic [15:0] fmask(input int a);
    logic [16:0] m;
    m = (17'd1 << fwidth(a)) - 17'd1;
    return m[15:0];
  endfunction

  function automatic logic [15:0] fdefault(input int a);
    case (a)
      0:       return 16'h001E;
      1:       return 16'h0019;
      4:       return 16'h000C;
      5:       return 16'h0001;
      6:       return 16'h0002;
      22:      return 16'h001A;
      23:      return 16'h0010;
      25:      return 16'h000C;
      26:      return 16'h2710;
      27:      return 16'h0040;
      34:      return 16'h0004;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an array of stored words, handshake phase 0=idle 1=wait 2=done.
  logic [15:0] m_reg [0:N-1];
  int          m_st = 0;
  logic [15:0] m_dl = 16'h0, m_dh = 16'h0;
  bit          m_tx_h1, m_tx_h2, m_rx_h1, m_rx_h2, m_tx_p, m_rx_p;
  bit          m_valid = 1'b0;

  always @(posedge clk_reg) begin
    int a;
    a = int'(ca[7:1]);
    if (!reset) begin
      for (int i = 0; i < N; i++) m_reg[i] = fdefault(i);
      m_st = 0; m_dl = 16'h0; m_dh = 16'h0;
      m_tx_h1 = 0; m_tx_h2 = 0; m_rx_h1 = 0; m_rx_h2 = 0;
      m_tx_p = 0; m_rx_p = 0;
      m_valid = 1'b1;
    end else begin
      m_tx_p = m_tx_h1 && !m_tx_h2;
      m_rx_p = m_rx_h1 && !m_rx_h2;
      if (m_st == 1 && cpu_rd_grant_i) begin
        m_dl = cpu_rd_dout_i[15:0];
        m_dh = cpu_rd_dout_i[31:16];
        m_reg[29] = 16'h0;
        m_st = 2;
      end
      if (!csb && !wrb && a < N && fwidth(a) > 0) begin
        m_reg[a] = cd_in & fmask(a);
        if (a == 29) m_st = cd_in[0] ? 1 : 0;
      end
      m_tx_h2 = m_tx_h1; m_tx_h1 = m_reg[10][0];
      m_rx_h2 = m_rx_h1; m_rx_h1 = m_reg[17][0];
    end
  end

  always @(negedge clk_reg) begin
    logic [15:0] e;
    int a;
    if (m_valid) begin
      e = 16'h0;
      a = int'(ca[7:1]);
      if (!csb && wrb && a < N) begin
        if (a == 30)      e = {15'b0, m_st == 2};
        else if (a == 31) e = m_dl;
        else if (a == 32) e = m_dh;
        else              e = m_reg[a];
      end
      chk("cd_out", cd_out, e);
      chk("tx_prom_wr_pulse", tx_prom_wr_pulse, m_tx_p);
      chk("rx_prom_wr_pulse", rx_prom_wr_pulse, m_rx_p);
      chk("cfg_cpu_rd_apply", 16'(cfg.cpu_rd_apply), m_reg[29]);
      chk("cfg_pause_quanta_set", cfg.pause_quanta_set, m_reg[3]);
      chk("cfg_tx_hwmark", 16'(cfg.tx_hwmark), m_reg[0]);
      chk("cfg_rx_min_length", 16'(cfg.rx_min_length), m_reg[27]);
      chk("cfg_cpu_rd_addr", 16'(cfg.cpu_rd_addr), m_reg[28]);
      chk("cfg_speed", 16'(cfg.speed), m_reg[34]);
    end
    if (tx_prom_wr_pulse === 1'b1) tx_pulse_cnt++;
  end

  task automatic drive(input bit c, input bit w, input int a, input logic [15:0] d);
    csb   = c;
    wrb   = w;
    ca    = {a[6:0], 1'($urandom_range(1))};
    cd_in = d;
    @(posedge clk_reg);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    drive(1'b0, 1'b0, a, d);
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 0, 16'($urandom()));
  endtask

  task automatic rd_chk(input string nm, input int a, input logic [15:0] exp);
    csb = 1'b0;
    wrb = 1'b1;
    ca  = {a[6:0], 1'b1};
    @(negedge clk_reg);
    chk(nm, cd_out, exp);
    @(posedge clk_reg);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete by %0t", $time);
    $fatal(1);
  end

  initial begin
    int cnt0;
    @(posedge clk_reg);
    #1;
    repeat (3) idle();
    reset = 1'b1;

    rd_chk("rst_tx_hwmark", 0, 16'h001E);
    rd_chk("rst_tx_lwmark", 1, 16'h0019);
    rd_chk("rst_pause_quanta", 3, 16'h0000);
    rd_chk("rst_ifgset", 4, 16'h000C);
    rd_chk("rst_max_retry", 6, 16'h0002);
    rd_chk("rst_rx_max_length", 26, 16'h2710);
    rd_chk("rst_rx_min_length", 27, 16'h0040);
    rd_chk("rst_grant", 30, 16'h0000);
    rd_chk("rst_speed", 34, 16'h0004);
    for (int i = 0; i < N; i++) rd_chk("rst_sweep", i, fdefault(i));

    wr(3, 16'hFFFF);
    chk("cfg_pause_after_write", cfg.pause_quanta_set, 16'hFFFF);
    wr(0, 16'hFFFF);
    wr(40, 16'h1234);
    rd_chk("rd_pause_quanta", 3, 16'hFFFF);
    rd_chk("rd_tx_hwmark_trunc", 0, 16'h001F);
    rd_chk("rd_unmapped", 40, 16'h0000);
    wr(31, 16'hABCD);
    rd_chk("rd_only_dout_l", 31, 16'h0000);

    cnt0 = tx_pulse_cnt;
    wr(10, 16'h0001); idle(); idle();
    wr(10, 16'h0001); idle(); idle();
    wr(10, 16'h0000); idle();
    wr(10, 16'h0001);
    repeat (4) idle();
    chk("tx_pulse_count", tx_pulse_cnt - cnt0, 2);

    wr(29, 16'h0001);
    idle(); idle();
    rd_chk("apply_in_wait", 29, 16'h0001);
    idle(); idle();
    cpu_rd_grant_i = 1'b1;
    cpu_rd_dout_i  = 32'hDEADBEEF;
    idle();
    cpu_rd_grant_i = 1'b0;
    rd_chk("dout_l", 31, 16'hBEEF);
    rd_chk("dout_h", 32, 16'hDEAD);
    rd_chk("grant_done", 30, 16'h0001);
    rd_chk("apply_cleared", 29, 16'h0000);
    cpu_rd_grant_i = 1'b1;
    cpu_rd_dout_i  = 32'h11112222;
    idle();
    cpu_rd_grant_i = 1'b0;
    rd_chk("grant_ignored_done", 31, 16'hBEEF);

    wr(29, 16'h0001);
    cpu_rd_grant_i = 1'b1;
    cpu_rd_dout_i  = 32'h12345678;
    wr(29, 16'h0000);
    cpu_rd_grant_i = 1'b0;
    rd_chk("collide_dout_l", 31, 16'h5678);
    rd_chk("collide_dout_h", 32, 16'h1234);
    rd_chk("collide_idle_grant", 30, 16'h0000);
    rd_chk("collide_apply", 29, 16'h0000);

    wr(29, 16'h0001);
    reset          = 1'b0;
    cpu_rd_grant_i = 1'b1;
    cpu_rd_dout_i  = 32'hCAFEF00D;
    wr(29, 16'h0001);
    reset          = 1'b1;
    cpu_rd_grant_i = 1'b0;
    chk("reset_abort_cfg_apply", 16'(cfg.cpu_rd_apply), 16'h0000);
    rd_chk("reset_abort_apply", 29, 16'h0000);
    rd_chk("reset_abort_dout_l", 31, 16'h0000);
    rd_chk("reset_abort_dout_h", 32, 16'h0000);
    rd_chk("reset_abort_grant", 30, 16'h0000);
    rd_chk("reset_restores_hwmark", 0, 16'h001E);

    for (int i = 0; i < 3000; i++) begin
      int a;
      int r;
      r = int'($urandom_range(99));
      case ($urandom_range(3))
        0:       a = 29;
        1:       a = int'($urandom_range(45));
        2:       a = (r < 50) ? 10 : 17;
        default: a = int'($urandom_range(34));
      endcase
      cpu_rd_grant_i = ($urandom_range(3) == 0);
      cpu_rd_dout_i  = $urandom();
      reset          = ($urandom_range(199) != 0);
      drive($urandom_range(4) == 0, 1'($urandom_range(1)), a, 16'($urandom()));
    end
    reset          = 1'b1;
    cpu_rd_grant_i = 1'b0;
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
